// File: rtl/bringup_wb_arbiter.sv
// bringup_wb_arbiter: round-robin two-requester master for the wbs_* port.
// One single-beat cycle at a time; a missing ack ends as an error response.
module bringup_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [31:0] req0_adr,
  input  logic [31:0] req0_dat,
  input  logic [3:0]  req0_sel,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_dat,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [31:0] req1_adr,
  input  logic [31:0] req1_dat,
  input  logic [3:0]  req1_sel,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_dat,
  output logic        rsp1_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic                rdy0_q, rdy0_d;
  logic                rdy1_q, rdy1_d;
  logic                rv0_q, rv0_d;
  logic                rv1_q, rv1_d;
  logic [31:0]         rd0_q, rd0_d;
  logic [31:0]         rd1_q, rd1_d;
  logic                re0_q, re0_d;
  logic                re1_q, re1_d;

  logic        pick;
  logic        done;
  logic        err;
  logic [31:0] rdat;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    re0_d   = re0_q;
    re1_d   = re1_q;
    done    = 1'b0;
    err     = 1'b0;
    rdat    = '0;
    pick    = 1'b0;

    // on contention the requester not granted last time wins
    unique case (1'b1)
      req0_valid && req1_valid:  pick = ~last_q;
      req1_valid && !req0_valid: pick = 1'b1;
      default:                   pick = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = S_BUS;
          last_d  = pick;
          gnt_d   = pick;
          rdy0_d  = ~pick;
          rdy1_d  = pick;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          we_d    = pick ? req1_we  : req0_we;
          sel_d   = pick ? req1_sel : req0_sel;
          adr_d   = pick ? req1_adr : req0_adr;
          dat_d   = pick ? req1_dat : req0_dat;
        end
      end
      S_BUS: begin
        // ack beats a timeout landing in the same cycle
        if (wbs_ack_i) begin
          done = 1'b1;
          rdat = we_q ? '0 : wbs_dat_i;
        end else if (cnt_q == TO_LAST) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d = S_IDLE;
      cyc_d   = 1'b0;
      if (gnt_q) begin
        rv1_d = 1'b1;
        rd1_d = rdat;
        re1_d = err;
      end else begin
        rv0_d = 1'b1;
        rd0_d = rdat;
        re0_d = err;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      re0_q   <= 1'b0;
      re1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      re0_q   <= re0_d;
      re1_q   <= re1_d;
    end
  end

  assign req0_ready = rdy0_q;
  assign req1_ready = rdy1_q;
  assign rsp0_valid = rv0_q;
  assign rsp1_valid = rv1_q;
  assign rsp0_dat   = rd0_q;
  assign rsp1_dat   = rd1_q;
  assign rsp0_err   = re0_q;
  assign rsp1_err   = re1_q;
  assign wbs_cyc_o  = cyc_q;
  assign wbs_stb_o  = cyc_q;
  assign busy       = cyc_q;
  assign wbs_we_o   = we_q;
  assign wbs_sel_o  = sel_q;
  assign wbs_adr_o  = adr_q;
  assign wbs_dat_o  = dat_q;

endmodule

// File: tb/tb_bringup_wb_arbiter.sv
// tb_bringup_wb_arbiter: directed scenarios plus randomized batches
// scored against a round-robin transaction-level model.
module tb_bringup_wb_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] KEY = 32'hFAFE_F009;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  typedef struct packed {
    txn_t t;
    int   rise;
    int   len;
    logic stable;
  } bus_t;

  typedef struct packed {
    int          who;
    logic [31:0] dat;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct packed {
    int who;
    int cyc;
    int vcyc;
  } rdy_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        vld0 = 1'b0;
  logic        vld1 = 1'b0;
  txn_t        cur0 = '0;
  txn_t        cur1 = '0;
  logic        ack = 1'b0;
  logic [31:0] sdat = '0;
  logic        stray = 1'b0;

  logic        rdy0, rdy1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, busy;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;

  int   cyc_no = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   sig_bad = 0;
  logic m_last = 1'b1;

  txn_t pend0[$];
  txn_t pend1[$];
  int   lat_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  rdy_t rdy_q[$];

  bringup_wb_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req0_valid(vld0),
    .req0_ready(rdy0),
    .req0_we(cur0.we),
    .req0_adr(cur0.adr),
    .req0_dat(cur0.dat),
    .req0_sel(cur0.sel),
    .rsp0_valid(rv0),
    .rsp0_dat(rd0),
    .rsp0_err(re0),
    .req1_valid(vld1),
    .req1_ready(rdy1),
    .req1_we(cur1.we),
    .req1_adr(cur1.adr),
    .req1_dat(cur1.dat),
    .req1_sel(cur1.sel),
    .rsp1_valid(rv1),
    .rsp1_dat(rd1),
    .rsp1_err(re1),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_ack_i(ack),
    .wbs_dat_i(sdat),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_no <= cyc_no + 1;

  // requesters, slave and bus monitor share one process so their
  // per-cycle ordering is fixed
  initial begin : bfm
    logic pcyc;
    int   scnt;
    int   slat;
    int   vc0;
    int   vc1;
    bus_t cb;
    pcyc = 1'b0;
    scnt = 0;
    slat = 1;
    vc0 = 0;
    vc1 = 0;
    cb = '0;
    forever begin
      @(posedge clock);
      #1;
      if (wbs_cyc_o && !pcyc) begin
        cb.t = '{we: wbs_we_o, adr: wbs_adr_o,
                 dat: wbs_dat_o, sel: wbs_sel_o};
        cb.rise = cyc_no;
        cb.len = 1;
        cb.stable = 1'b1;
        scnt = 0;
        slat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      end else if (wbs_cyc_o) begin
        cb.len++;
        if ({wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o} != cb.t)
          cb.stable = 1'b0;
      end
      if (!wbs_cyc_o && pcyc) bus_q.push_back(cb);
      pcyc = wbs_cyc_o;
      if (wbs_stb_o !== wbs_cyc_o || busy !== wbs_cyc_o) sig_bad++;
      if (rv0 && rv1) sig_bad++;
      if (rv0) rsp_q.push_back('{who: 0, dat: rd0, err: re0, cyc: cyc_no});
      if (rv1) rsp_q.push_back('{who: 1, dat: rd1, err: re1, cyc: cyc_no});
      if (rdy0) rdy_q.push_back('{who: 0, cyc: cyc_no, vcyc: vc0});
      if (rdy1) rdy_q.push_back('{who: 1, cyc: cyc_no, vcyc: vc1});
      if (wbs_cyc_o) begin
        scnt++;
        ack = (scnt == slat);
      end else begin
        ack = stray;
      end
      sdat = ack ? (wbs_adr_o ^ KEY) : $urandom;
      if (vld0 && rdy0) vld0 = 1'b0;
      if (vld1 && rdy1) vld1 = 1'b0;
      if (!vld0 && pend0.size() > 0) begin
        cur0 = pend0.pop_front();
        vld0 = 1'b1;
        vc0 = cyc_no;
      end
      if (!vld1 && pend1.size() > 0) begin
        cur1 = pend1.pop_front();
        vld1 = 1'b1;
        vc1 = cyc_no;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic flush();
    bus_q.delete();
    rsp_q.delete();
    rdy_q.delete();
    lat_q.delete();
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 1000) begin
      @(negedge clock);
      k++;
    end
    ok = (rsp_q.size() >= n);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we  = 1'($urandom_range(0, 1));
    t.adr = $urandom & 32'hFFFF_FFFC;
    t.dat = $urandom;
    t.sel = 4'($urandom_range(1, 15));
    return t;
  endfunction

  task automatic test_reset();
    tick(3);
    n_chk++;
    if ({wbs_cyc_o, wbs_stb_o, busy, rdy0, rdy1, rv0, rv1, re0, re1,
         wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, rd0, rd1} !== '0)
      $display("FAIL reset_outputs: some output nonzero, want all 0");
    else n_pass++;
    reset_n = 1'b1;
    m_last = 1'b1;
    tick(3);
    n_chk++;
    if ({wbs_cyc_o, rdy0, rdy1, rv0, rv1} !== 5'b0)
      $display("FAIL idle_after_reset: %b want 00000",
               {wbs_cyc_o, rdy0, rdy1, rv0, rv1});
    else n_pass++;
  endtask

  task automatic test_single_write();
    txn_t t;
    bit   ok;
    t = '{we: 1'b1, adr: 32'h3000_0000, dat: 32'hA5A5_1234, sel: 4'hF};
    flush();
    lat_q.push_back(3);
    pend0.push_back(t);
    wait_rsp(1, ok);
    tick(3);
    n_chk++;
    if (!ok) $display("FAIL wr_done: rsp count %0d want 1", rsp_q.size());
    else n_pass++;
    n_chk++;
    if (bus_q.size() != 1 || bus_q[0].t !== t || !bus_q[0].stable)
      $display("FAIL wr_bus: cycles=%0d fields=%h want 1 %h",
               bus_q.size(), bus_q[0].t, t);
    else n_pass++;
    n_chk++;
    if (bus_q[0].len != 3)
      $display("FAIL wr_cyc_len: %0d want 3", bus_q[0].len);
    else n_pass++;
    n_chk++;
    if (rdy_q.size() != 1 || rdy_q[0].who != 0 ||
        rdy_q[0].cyc != rdy_q[0].vcyc + 1 ||
        bus_q[0].rise != rdy_q[0].cyc)
      $display("FAIL wr_ready: n=%0d who=%0d lat=%0d want 1 0 1",
               rdy_q.size(), rdy_q[0].who,
               rdy_q[0].cyc - rdy_q[0].vcyc);
    else n_pass++;
    n_chk++;
    if (rsp_q.size() != 1 || rsp_q[0].who != 0 || rsp_q[0].dat !== 0 ||
        rsp_q[0].err !== 1'b0 || rsp_q[0].cyc != bus_q[0].rise + 3)
      $display("FAIL wr_rsp: n=%0d who=%0d dat=%h err=%b want 1 0 0 0",
               rsp_q.size(), rsp_q[0].who, rsp_q[0].dat, rsp_q[0].err);
    else n_pass++;
    m_last = 1'b0;
  endtask

  task automatic test_single_read();
    txn_t t;
    bit   ok;
    t = '{we: 1'b0, adr: 32'h3000_0004, dat: 32'h1111_2222, sel: 4'hF};
    flush();
    lat_q.push_back(2);
    pend1.push_back(t);
    wait_rsp(1, ok);
    tick(4);
    n_chk++;
    if (!ok || rsp_q.size() != 1 || rsp_q[0].who != 1)
      $display("FAIL rd_rsp_who: n=%0d who=%0d want 1 1",
               rsp_q.size(), rsp_q[0].who);
    else n_pass++;
    n_chk++;
    if (rsp_q[0].dat !== 32'hCAFE_F00D || rsp_q[0].err !== 1'b0)
      $display("FAIL rd_data: %h err=%b want cafef00d 0",
               rsp_q[0].dat, rsp_q[0].err);
    else n_pass++;
    n_chk++;
    if (rd1 !== 32'hCAFE_F00D || rv1 !== 1'b0)
      $display("FAIL rd_hold: rsp1_dat=%h want cafef00d", rd1);
    else n_pass++;
    m_last = 1'b1;
  endtask

  task automatic test_contention();
    bit ok;
    flush();
    for (int i = 0; i < 4; i++) lat_q.push_back(1);
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(rand_txn());
      pend1.push_back(rand_txn());
    end
    wait_rsp(4, ok);
    tick(3);
    n_chk++;
    if (!ok || bus_q.size() != 4)
      $display("FAIL cont_count: cycles=%0d want 4", bus_q.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (rdy_q[i].who != i % 2 || rsp_q[i].who != i % 2)
        $display("FAIL cont_order[%0d]: rdy=%0d rsp=%0d want %0d",
                 i, rdy_q[i].who, rsp_q[i].who, i % 2);
      else n_pass++;
    end
    for (int i = 1; i < 4; i++) begin
      n_chk++;
      if (bus_q[i].rise != bus_q[i-1].rise + bus_q[i-1].len + 1)
        $display("FAIL cont_gap[%0d]: idle=%0d want 1", i,
                 bus_q[i].rise - bus_q[i-1].rise - bus_q[i-1].len);
      else n_pass++;
    end
    m_last = 1'b1;
  endtask

  task automatic test_timeout();
    txn_t a;
    txn_t b;
    bit   ok;
    a = '{we: 1'b0, adr: 32'h3000_0008, dat: 32'h0, sel: 4'hF};
    b = '{we: 1'b0, adr: 32'h3000_000C, dat: 32'h0, sel: 4'h3};
    flush();
    lat_q.push_back(0);
    lat_q.push_back(2);
    pend0.push_back(a);
    pend0.push_back(b);
    wait_rsp(2, ok);
    tick(3);
    n_chk++;
    if (!ok || bus_q[0].len != TO)
      $display("FAIL to_len: %0d want %0d", bus_q[0].len, TO);
    else n_pass++;
    n_chk++;
    if (rsp_q[0].who != 0 || rsp_q[0].err !== 1'b1 || rsp_q[0].dat !== 0)
      $display("FAIL to_rsp: who=%0d err=%b dat=%h want 0 1 0",
               rsp_q[0].who, rsp_q[0].err, rsp_q[0].dat);
    else n_pass++;
    n_chk++;
    if (rsp_q[1].err !== 1'b0 || rsp_q[1].dat !== (b.adr ^ KEY) ||
        bus_q[1].len != 2)
      $display("FAIL to_next: err=%b dat=%h len=%0d want 0 %h 2",
               rsp_q[1].err, rsp_q[1].dat, bus_q[1].len, b.adr ^ KEY);
    else n_pass++;
    m_last = 1'b0;
  endtask

  task automatic test_stray_ack();
    txn_t t;
    bit   ok;
    flush();
    stray = 1'b1;
    tick(4);
    stray = 1'b0;
    tick(3);
    n_chk++;
    if (rsp_q.size() != 0 || bus_q.size() != 0)
      $display("FAIL stray_ack: rsp=%0d cyc=%0d want 0 0",
               rsp_q.size(), bus_q.size());
    else n_pass++;
    t = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'h0, sel: 4'hF};
    lat_q.push_back(TO);
    pend1.push_back(t);
    wait_rsp(1, ok);
    tick(2);
    n_chk++;
    if (!ok || bus_q[0].len != TO || rsp_q[0].err !== 1'b0 ||
        rsp_q[0].dat !== (t.adr ^ KEY))
      $display("FAIL coincident_ack: len=%0d err=%b dat=%h want %0d 0 %h",
               bus_q[0].len, rsp_q[0].err, rsp_q[0].dat, TO, t.adr ^ KEY);
    else n_pass++;
    m_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    txn_t t;
    bit   ok;
    int   k;
    flush();
    lat_q.push_back(0);
    pend0.push_back(rand_txn());
    k = 0;
    while (!wbs_cyc_o && k < 20) begin
      tick(1);
      k++;
    end
    tick(2);
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({wbs_cyc_o, wbs_stb_o, busy} !== 3'b000)
      $display("FAIL rst_async: cyc/stb/busy=%b want 000",
               {wbs_cyc_o, wbs_stb_o, busy});
    else n_pass++;
    tick(2);
    reset_n = 1'b1;
    m_last = 1'b1;
    tick(TO + 4);
    n_chk++;
    if (rsp_q.size() != 0)
      $display("FAIL rst_no_rsp: rsp=%0d want 0", rsp_q.size());
    else n_pass++;
    flush();
    t = '{we: 1'b0, adr: 32'h3000_0020, dat: 32'h0, sel: 4'hF};
    lat_q.push_back(1);
    pend1.push_back(t);
    wait_rsp(1, ok);
    tick(2);
    n_chk++;
    if (!ok || rdy_q[0].who != 1 || rsp_q[0].who != 1 ||
        rsp_q[0].err !== 1'b0 || rsp_q[0].dat !== (t.adr ^ KEY))
      $display("FAIL rst_recover: who=%0d err=%b dat=%h want 1 0 %h",
               rsp_q[0].who, rsp_q[0].err, rsp_q[0].dat, t.adr ^ KEY);
    else n_pass++;
    m_last = 1'b1;
  endtask

  task automatic test_random();
    for (int b = 0; b < 15; b++) begin
      txn_t        q0[$];
      txn_t        q1[$];
      txn_t        ot[$];
      int          ord[$];
      int          lat[$];
      int          n0;
      int          n1;
      int          g;
      logic        last;
      bit          ok;
      bit          good;
      int          elen;
      logic        eerr;
      logic [31:0] edat;
      logic [32:0] h0;
      logic [32:0] h1;
      bit          s0;
      bit          s1;
      q0.delete();
      q1.delete();
      ot.delete();
      ord.delete();
      lat.delete();
      s0 = 1'b0;
      s1 = 1'b0;
      h0 = '0;
      h1 = '0;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) q0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) q1.push_back(rand_txn());
      flush();
      foreach (q0[i]) pend0.push_back(q0[i]);
      foreach (q1[i]) pend1.push_back(q1[i]);
      last = m_last;
      while (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() > 0 && q1.size() > 0) g = last ? 0 : 1;
        else g = (q1.size() > 0) ? 1 : 0;
        last = 1'(g);
        ord.push_back(g);
        ot.push_back(g ? q1.pop_front() : q0.pop_front());
        lat.push_back($urandom_range(0, 10));
        lat_q.push_back(lat[lat.size()-1]);
      end
      m_last = last;
      wait_rsp(ord.size(), ok);
      tick(3);
      n_chk++;
      if (!ok || rsp_q.size() != ord.size())
        $display("FAIL rnd_count[%0d]: rsp=%0d want %0d",
                 b, rsp_q.size(), ord.size());
      else n_pass++;
      for (int k = 0; k < ord.size(); k++) begin
        good = (lat[k] >= 1 && lat[k] <= TO);
        elen = good ? lat[k] : TO;
        eerr = !good;
        edat = (good && !ot[k].we) ? (ot[k].adr ^ KEY) : 32'h0;
        if (ord[k] == 0) begin
          h0 = {eerr, edat};
          s0 = 1'b1;
        end else begin
          h1 = {eerr, edat};
          s1 = 1'b1;
        end
        n_chk++;
        if (rdy_q[k].who != ord[k] || bus_q[k].t !== ot[k] ||
            !bus_q[k].stable || bus_q[k].len != elen)
          $display("FAIL rnd_bus[%0d.%0d]: who=%0d len=%0d want %0d %0d",
                   b, k, rdy_q[k].who, bus_q[k].len, ord[k], elen);
        else n_pass++;
        n_chk++;
        if (rsp_q[k].who != ord[k] || rsp_q[k].err !== eerr ||
            rsp_q[k].dat !== edat)
          $display("FAIL rnd_rsp[%0d.%0d]: who=%0d err=%b dat=%h want %0d %b %h",
                   b, k, rsp_q[k].who, rsp_q[k].err, rsp_q[k].dat,
                   ord[k], eerr, edat);
        else n_pass++;
        if (k > 0) begin
          n_chk++;
          if (bus_q[k].rise != bus_q[k-1].rise + bus_q[k-1].len + 1)
            $display("FAIL rnd_gap[%0d.%0d]: idle=%0d want 1", b, k,
                     bus_q[k].rise - bus_q[k-1].rise - bus_q[k-1].len);
          else n_pass++;
        end
      end
      if (s0) begin
        n_chk++;
        if ({re0, rd0} !== h0)
          $display("FAIL rnd_hold0[%0d]: %h want %h", b, {re0, rd0}, h0);
        else n_pass++;
      end
      if (s1) begin
        n_chk++;
        if ({re1, rd1} !== h1)
          $display("FAIL rnd_hold1[%0d]: %h want %h", b, {re1, rd1}, h1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_stray_ack();
    test_reset_mid();
    test_random();
    n_chk++;
    if (sig_bad != 0)
      $display("FAIL signal_rules: violations=%0d want 0", sig_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
